b_bit_source: RTL and testbench
===============================

# b_bit_source

Serial payload source for the 802.11b backscatter path. It builds a 32-bit tag frame: sync word, tag ID, captured RSS byte, and sequence number. The frame is shifted out MSB-first, one bit per 1 µs `bit_tick`, and `s_dat` drives the `s_in` of `b_modulator` and `fcs_for_xor`. It sits directly upstream of those blocks. It replaces the fixed `b_data` shift register in the tag top level.

## Interface

Parameters:
- `TAG_ID`, 8'h01: tag identifier, frame bits [23:16].
- `SYNC_WORD`, 8'h34: frame bits [31:24].
- `SCR_SEED`, 7'b1101100: scrambler seed. Used only when `B_BIT_SOURCE_SCRAMBLE_EN` is defined.

Ports:
- `clk`  in  1  50 MHz system clock.
- `reset`  in  1  synchronous, active-high.
- `load`  in  1  single-cycle pulse: capture `rss`, start a frame.
- `abort`  in  1  level; trig dropped, kill the frame.
- `bit_tick`  in  1  single-cycle strobe, once per µs (`next_us`).
- `rss`  in  8  RSS byte, sampled on accepted `load`.
- `s_dat`  out  1  current serial bit.
- `busy`  out  1  frame in progress.
- `done`  out  1  single-cycle pulse after the last bit completes.
- `bit_idx`  out  5  bits already shifted (0..31).
- `seq`  out  8  sequence number of the next frame.

## Operation

- Two-state FSM: IDLE and SHIFT.
- **IDLE:**
  - `s_dat`=0, `busy`=0, `bit_idx`=0.
  - `load`=1 with `abort`=0: `frame_sr` ← {`SYNC_WORD`, `TAG_ID`, `rss`, `seq`}, scrambler ← `SCR_SEED`, go to SHIFT.
- **SHIFT:**
  - `s_dat` = `frame_sr[31]`, scrambled if enabled. `busy`=1.
  - Each `bit_tick`: `frame_sr` ← `frame_sr` << 1, `bit_idx`++.
  - On the `bit_tick` with `bit_idx`==31: go to IDLE, `done`=1 for the following cycle, `seq` ← `seq`+1 (wraps 8'hFF→8'h00).
- **abort:** in SHIFT, go to IDLE on the next edge. No `done`, `seq` unchanged, `s_dat` forced to 0.
- **Input priority:**
  - `abort` > `load` > `bit_tick`.
  - `load` while in SHIFT is ignored; the frame is not restarted.
  - `load` and `bit_tick` in the same IDLE cycle: load only. The tick is not counted, so bit 31 holds a full tick period.
- **reset mid-frame:** same as reset from cold. `seq` returns to 0.
- **Reset values:** state IDLE, `s_dat`=0, `busy`=0, `done`=0, `bit_idx`=0, `seq`=0, `frame_sr`=0, scrambler=`SCR_SEED`.

## Timing

- `load` accepted at edge N: `busy` and the first bit are valid from N+1 (1-cycle latency).
- Each bit is held from its `bit_tick` edge until the next `bit_tick` edge, nominally 50 clk.
- `s_dat` comes from registers only (frame_sr[31], scrambler state), combined with at most one XOR gate. This keeps `s_dat` glitch-free enough for the `next_us`-clocked consumers.
- Frame duration is 32 ticks. `done` is asserted exactly 1 clk after the 32nd tick edge.
- `busy` falls on the same edge that `done` rises.
- `abort`: `busy` falls and `s_dat`=0 one clk after `abort` is sampled high.

## Configuration

- Macro: `B_BIT_SOURCE_SCRAMBLE_EN`.
- **Defined:** 802.11b self-synchronizing scrambler, polynomial z^-7 + z^-4 + 1.
  - `s_dat` = `frame_sr[31]` ^ `sc[3]` ^ `sc[6]`.
  - On each shifting tick: `sc` ← {`sc[5:0]`, `s_dat`}.
  - `sc` is reseeded on every accepted `load`.
- **Undefined:** `s_dat` = `frame_sr[31]`. No scrambler registers; `SCR_SEED` is unused.

## Structure

- Shared package `loctag_pkg`:
  - `B_FRAME_LEN`=32, `B_IDX_W`=5.
  - Default `B_SYNC_WORD`=8'h34.
  - FSM state enum {IDLE, SHIFT}.
- Sub-module `b_scrambler`:
  - Ports: `clk`, `reset`, `seed_load`, `shift`, `d_in`, `d_out`.
  - Instantiated only under `B_BIT_SOURCE_SCRAMBLE_EN`.

## Test plan

- **Plain frame:** macro off, reset, `rss`=8'h80, `load`, 32 ticks spaced 50 clk.
  - `s_dat` sequence = 0x34018000 MSB-first.
  - `done` pulses once; `seq`=1.
- **Back-to-back:** run 3 full frames.
  - Third frame's last byte = 8'h02.
  - `seq`=3 at the end.
  - Set `seq` wrap 8'hFF→8'h00 via 256 frames (or force) and confirm.
- **Abort mid-frame:** assert `abort` after 10 ticks.
  - `busy`=0 and `s_dat`=0 next clk.
  - No `done`; `seq` unchanged.
  - The next `load` restarts at bit 31 with a fresh `rss`.
- **Simultaneous events:**
  - `load`+`bit_tick` in the same cycle: `bit_idx` stays 0.
  - `load` during SHIFT: ignored, frame intact.
  - `load`+`abort` in IDLE: stays IDLE.
- **Scrambler:** macro on, seed 7'b1101100, frame 0x34018000.
  - First `s_dat`=0.
  - Full 32-bit output matches a software z^-7+z^-4+1 model.
  - A descrambler model recovers 0x34018000.
- **Reset mid-frame:** reset at tick 20.
  - All outputs return to reset values next clk.
  - `seq`=0.
  - The next frame is correct.

Source files
------------

// File: rtl/loctag_pkg.sv
// Shared constants and FSM state type for the loctag 802.11b backscatter path.
package loctag_pkg;
    localparam int unsigned B_FRAME_LEN = 32;
    localparam int unsigned B_IDX_W     = 5;
    localparam logic [7:0]  B_SYNC_WORD = 8'h34;

    typedef enum logic {
        IDLE,
        SHIFT
    } b_state_t;
endpackage

// File: rtl/b_scrambler.sv
// 802.11b self-synchronizing scrambler (z^-7 + z^-4 + 1).
// Its output is the input bit XORed with two register taps.
module b_scrambler #(
    parameter logic [6:0] SEED = 7'b1101100
) (
    input  logic clk,
    input  logic reset,
    input  logic seed_load,
    input  logic shift,
    input  logic d_in,
    output logic d_out
);
    logic [6:0] sc;

    assign d_out = d_in ^ sc[3] ^ sc[6];

    always_ff @(posedge clk) begin
        if (reset) begin
            sc <= SEED;
        end else if (seed_load) begin
            sc <= SEED;
        end else if (shift) begin
            sc <= {sc[5:0], d_out};
        end
    end
endmodule

// File: rtl/b_bit_source.sv
// Serial 32-bit tag frame source {sync, tag id, rss, seq}, shifted out MSB-first on bit_tick.
// Optional scrambling is enabled with `define B_BIT_SOURCE_SCRAMBLE_EN.
module b_bit_source
    import loctag_pkg::*;
#(
    parameter logic [7:0] TAG_ID    = 8'h01,
    parameter logic [7:0] SYNC_WORD = B_SYNC_WORD,
    parameter logic [6:0] SCR_SEED  = 7'b1101100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               abort,
    input  logic               bit_tick,
    input  logic [7:0]         rss,
    output logic               s_dat,
    output logic               busy,
    output logic               done,
    output logic [B_IDX_W-1:0] bit_idx,
    output logic [7:0]         seq
);
    b_state_t               state_q, state_d;
    logic [B_FRAME_LEN-1:0] frame_sr;
    logic                   load_ok;
    logic                   shift_en;
    logic                   last_bit;
    logic                   tx_bit;

    assign busy     = (state_q == SHIFT);
    // A load in IDLE swallows any simultaneous tick, so bit 31 gets a full tick period.
    assign load_ok  = (state_q == IDLE) && load && !abort;
    assign shift_en = busy && bit_tick && !abort;
    assign last_bit = shift_en && (bit_idx == B_IDX_W'(B_FRAME_LEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_ok) state_d = SHIFT;
            SHIFT:   if (abort || last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_sr <= '0;
            bit_idx  <= '0;
            seq      <= '0;
            done     <= 1'b0;
        end else begin
            done <= last_bit;
            if (load_ok) begin
                frame_sr <= {SYNC_WORD, TAG_ID, rss, seq};
                bit_idx  <= '0;
            end else if (busy && abort) begin
                frame_sr <= '0;
                bit_idx  <= '0;
            end else if (shift_en) begin
                frame_sr <= {frame_sr[B_FRAME_LEN-2:0], 1'b0};
                bit_idx  <= bit_idx + B_IDX_W'(1);
                if (last_bit) begin
                    seq <= seq + 8'd1;
                end
            end
        end
    end

`ifdef B_BIT_SOURCE_SCRAMBLE_EN
    b_scrambler #(
        .SEED(SCR_SEED)
    ) u_scrambler (
        .clk      (clk),
        .reset    (reset),
        .seed_load(load_ok),
        .shift    (shift_en),
        .d_in     (frame_sr[B_FRAME_LEN-1]),
        .d_out    (tx_bit)
    );
`else
    logic unused_scr_seed;
    assign unused_scr_seed = ^SCR_SEED;
    assign tx_bit          = frame_sr[B_FRAME_LEN-1];
`endif

    assign s_dat = busy & tx_bit;
endmodule

// File: tb/tb_b_bit_source.sv
// Directed self-checking bench for b_bit_source: frames, back-to-back, abort, priority, reset, seq wrap.
module tb_b_bit_source;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       abort = 1'b0;
    logic       bit_tick = 1'b0;
    logic [7:0] rss = 8'h00;
    logic       s_dat;
    logic       busy;
    logic       done;
    logic [4:0] bit_idx;
    logic [7:0] seq;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_seq  = 8'h00;
    logic [31:0] got_word;

    always #10 clk = ~clk;

    b_bit_source #(
        .TAG_ID   (8'h01),
        .SYNC_WORD(8'h34),
        .SCR_SEED (7'b1101100)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .abort   (abort),
        .bit_tick(bit_tick),
        .rss     (rss),
        .s_dat   (s_dat),
        .busy    (busy),
        .done    (done),
        .bit_idx (bit_idx),
        .seq     (seq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected on-air word for a given frame word.
    function automatic logic [31:0] model_stream(input logic [31:0] frame);
        logic [31:0] out;
        logic [6:0]  sc;
        logic        b;
        out = frame;
        sc  = 7'b1101100;
`ifdef B_BIT_SOURCE_SCRAMBLE_EN
        for (int i = 31; i >= 0; i--) begin
            b      = frame[i] ^ sc[3] ^ sc[6];
            out[i] = b;
            sc     = {sc[5:0], b};
        end
`else
        b  = 1'b0;
        sc = sc ^ {6'b0, b};
`endif
        return out;
    endfunction

    // Sends load together with bit_tick, then 32 ticks spaced gap+1 clocks.
    task automatic run_frame(input logic [7:0] r, input int unsigned gap, input bit inject_load,
                             output logic [31:0] got);
        got = '0;
        @(negedge clk);
        rss = r; load = 1'b1; bit_tick = 1'b1;
        @(negedge clk);
        load = 1'b0; bit_tick = 1'b0; rss = ~r;
        check("load_busy", busy, 1);
        check("load_tick_idx", bit_idx, 0);
        for (int i = 0; i < 32; i++) begin
            got[31-i] = s_dat;
            if (i == 16) check("mid_idx", bit_idx, 16);
            for (int g = 0; g < int'(gap); g++) begin
                if (inject_load && i == 5 && g == 0) load = 1'b1;
                @(negedge clk);
                load = 1'b0;
            end
            bit_tick = 1'b1;
            @(negedge clk);
            bit_tick = 1'b0;
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_sdat", s_dat, 0);
        exp_seq = exp_seq + 8'd1;
        check("end_seq", seq, exp_seq);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    // Starts a frame and sends n ticks without finishing it.
    task automatic start_partial(input logic [7:0] r, input int unsigned n);
        @(negedge clk);
        rss = r; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            repeat (2) @(negedge clk);
            bit_tick = 1'b1;
            @(negedge clk);
            bit_tick = 0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_sdat", s_dat, 0);
        check("rst_done", done, 0);
        check("rst_idx", bit_idx, 0);
        check("rst_seq", seq, 0);

        // Plain frame with 50-clk bit period; a load mid-frame must be ignored.
        run_frame(8'h80, 49, 1'b1, got_word);
        check("frame1", got_word, model_stream(32'h3401_8000));

        // Back-to-back frames.
        run_frame(8'h11, 3, 1'b0, got_word);
        check("frame2", got_word, model_stream(32'h3401_1101));
        run_frame(8'h22, 3, 1'b0, got_word);
        check("frame3", got_word, model_stream(32'h3401_2202));
        check("seq3", seq, 3);

        // Abort after 10 ticks.
        start_partial(8'h5A, 10);
        check("pre_abort_idx", bit_idx, 10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sdat", s_dat, 0);
        check("abort_idx", bit_idx, 0);
        check("abort_done", done, 0);
        repeat (3) @(negedge clk);
        check("abort_done_late", done, 0);
        check("abort_seq", seq, 3);
        run_frame(8'hC3, 2, 1'b0, got_word);
        check("after_abort", got_word, model_stream(32'h3401_C303));

        // load + abort in IDLE stays idle.
        @(negedge clk);
        load = 1'b1; abort = 1'b1;
        @(negedge clk);
        load = 1'b0; abort = 1'b0;
        check("ldab_busy", busy, 0);
        check("ldab_seq", seq, 4);

        // Reset at tick 20.
        start_partial(8'h77, 20);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_seq = 8'h00;
        check("mrst_busy", busy, 0);
        check("mrst_sdat", s_dat, 0);
        check("mrst_done", done, 0);
        check("mrst_idx", bit_idx, 0);
        check("mrst_seq", seq, 0);
        run_frame(8'h80, 2, 1'b0, got_word);
        check("after_rst", got_word, model_stream(32'h3401_8000));

        // Walk seq up to 8'hFF and across the wrap.
        for (int f = 0; f < 254; f++) begin
            run_frame(8'(f), 1, 1'b0, got_word);
        end
        check("seq_ff", seq, 8'hFF);
        run_frame(8'hA5, 1, 1'b0, got_word);
        check("frame_ff", got_word, model_stream(32'h3401_A5FF));
        check("seq_wrap", seq, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
